// File: rtl/bit_scan_unit_if.sv
// bit_scan_unit_if: operand/result handshake bundle for bit_scan_unit.
//   in_valid/in_ready  : operand handshake (in_data, in_op)
//   out_valid/out_ready: result handshake (out_count, out_none)
//   master modport     : the requester side (drives operands, consumes results)
//   slave modport      : the scan unit side
interface bit_scan_unit_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    out_count;
   logic             out_none;

   modport master (
      output in_valid, in_data, in_op, out_ready,
      input  in_ready, out_valid, out_count, out_none
   );

   modport slave (
      input  in_valid, in_data, in_op, out_ready,
      output in_ready, out_valid, out_count, out_none
   );
endinterface

// File: rtl/bit_scan_unit.sv
// bit_scan_unit: multi-cycle leading/trailing zero/one counter.
// Scans CHUNK bits per cycle from the top of a shift register and stops at the
// first chunk holding the target bit. All four modes are mapped onto a CLZ scan
// by reversing and/or inverting the operand at accept time.
//   clk   : clock, rising edge
//   reset : synchronous, active-low
//   bus   : bit_scan_unit_if slave
//             in_valid/in_ready/in_data/in_op (00 CLZ, 01 CTZ, 10 CLO, 11 CTO)
//             out_valid/out_ready/out_count/out_none
module bit_scan_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 4
) (
   input  logic           clk,
   input  logic           reset,
   bit_scan_unit_if.slave bus
);

   localparam int unsigned CW     = $clog2(WIDTH + 1);
   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int unsigned LW     = $clog2(CHUNK + 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    acc_q, acc_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             none_q, none_d;

   logic [WIDTH-1:0] rev;
   logic [WIDTH-1:0] operand;
   logic [CHUNK-1:0] chunk;
   logic [LW-1:0]    chunk_lz;

   // op[0] selects a trailing scan (bit reverse), op[1] counts ones (invert).
   always_comb begin
      rev = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         rev[i] = bus.in_op[0] ? bus.in_data[int'(WIDTH) - 1 - i] : bus.in_data[i];
      end
      operand = bus.in_op[1] ? ~rev : rev;
   end

   assign chunk = sreg_q[WIDTH-1 -: CHUNK];

   // Ascending loop: the highest set bit writes last and wins.
   always_comb begin
      chunk_lz = LW'(CHUNK);
      for (int i = 0; i < int'(CHUNK); i++) begin
         if (chunk[i]) chunk_lz = LW'(int'(CHUNK) - 1 - i);
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      none_d  = none_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               sreg_d  = operand;
               acc_d   = '0;
               idx_d   = '0;
               none_d  = 1'b0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (chunk != '0) begin
               acc_d   = acc_q + CW'(chunk_lz);
               none_d  = 1'b0;
               state_d = StDone;
            end else if (idx_q == IW'(NCHUNK - 1)) begin
               acc_d   = CW'(WIDTH);
               none_d  = 1'b1;
               state_d = StDone;
            end else begin
               acc_d  = acc_q + CW'(CHUNK);
               sreg_d = sreg_q << CHUNK;
               idx_d  = idx_q + IW'(1);
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         sreg_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         none_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         none_q  <= none_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.out_count = acc_q;
   assign bus.out_none  = none_q;

endmodule

// File: tb/tb_bit_scan_unit.sv
// Bench for bit_scan_unit: three instances (32/4, 16/2, 64/8) share one set of
// drive signals; sel picks which one is driven and observed.
module tb_bit_scan_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int          sel = 0;
   logic        drv_valid = 1'b0;
   logic        drv_ready = 1'b0;
   logic [63:0] drv_data = '0;
   logic [1:0]  drv_op = 2'b00;

   logic        obs_valid, obs_in_ready, obs_none;
   logic [6:0]  obs_count;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   bit_scan_unit_if #(.WIDTH(32)) b32 ();
   bit_scan_unit_if #(.WIDTH(16)) b16 ();
   bit_scan_unit_if #(.WIDTH(64)) b64 ();

   assign b32.in_valid  = drv_valid && (sel == 0);
   assign b32.out_ready = drv_ready && (sel == 0);
   assign b32.in_data   = drv_data[31:0];
   assign b32.in_op     = drv_op;
   assign b16.in_valid  = drv_valid && (sel == 1);
   assign b16.out_ready = drv_ready && (sel == 1);
   assign b16.in_data   = drv_data[15:0];
   assign b16.in_op     = drv_op;
   assign b64.in_valid  = drv_valid && (sel == 2);
   assign b64.out_ready = drv_ready && (sel == 2);
   assign b64.in_data   = drv_data;
   assign b64.in_op     = drv_op;

   bit_scan_unit #(.WIDTH(32), .CHUNK(4)) u_dut32 (.clk(clk), .reset(reset), .bus(b32));
   bit_scan_unit #(.WIDTH(16), .CHUNK(2)) u_dut16 (.clk(clk), .reset(reset), .bus(b16));
   bit_scan_unit #(.WIDTH(64), .CHUNK(8)) u_dut64 (.clk(clk), .reset(reset), .bus(b64));

   always_comb begin
      case (sel)
         0: begin
            obs_valid = b32.out_valid; obs_in_ready = b32.in_ready;
            obs_none = b32.out_none; obs_count = 7'(b32.out_count);
         end
         1: begin
            obs_valid = b16.out_valid; obs_in_ready = b16.in_ready;
            obs_none = b16.out_none; obs_count = 7'(b16.out_count);
         end
         default: begin
            obs_valid = b64.out_valid; obs_in_ready = b64.in_ready;
            obs_none = b64.out_none; obs_count = 7'(b64.out_count);
         end
      endcase
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: walk bits from the scanned end, count until the target appears.
   function automatic int ref_count(input logic [63:0] d, input int w, input logic [1:0] op);
      int  cnt = 0;
      bit  hit = 0;
      bit  target = op[1] ? 1'b0 : 1'b1;
      for (int i = 0; i < w; i++) begin
         int pos = op[0] ? i : w - 1 - i;
         if (!hit) begin
            if (d[pos] == target) hit = 1;
            else cnt++;
         end
      end
      return cnt;
   endfunction

   task automatic issue(input logic [1:0] op, input logic [63:0] d);
      chk("ready_before_issue", int'(obs_in_ready), 1);
      drv_op    = op;
      drv_data  = d;
      drv_valid = 1'b1;
      step();
      drv_valid = 1'b0;
      drv_data  = $urandom;  // must be ignored while busy
      drv_op    = 2'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!obs_valid && lat < 200) begin
         step();
         lat++;
      end
      chk("valid_seen", int'(obs_valid), 1);
   endtask

   task automatic drain();
      drv_ready = 1'b1;
      step();
      drv_ready = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [63:0] d,
                         output int cnt, output int none, output int lat);
      issue(op, d);
      wait_valid(lat);
      cnt  = int'(obs_count);
      none = int'(obs_none);
      drain();
   endtask

   initial begin
      int cnt, none, lat, seen;
      int w, c, sh, exp_cnt, exp_lat;
      logic [63:0] d, mask;

      // Reset state of every instance
      repeat (3) step();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk("rst_in_ready", int'(obs_in_ready), 1);
         chk("rst_out_valid", int'(obs_valid), 0);
         chk("rst_out_count", int'(obs_count), 0);
         chk("rst_out_none", int'(obs_none), 0);
      end
      reset = 1'b1;
      sel = 0;
      step();

      // Directed, WIDTH=32 CHUNK=4
      run_op(2'b00, 64'h0000_0ABC, cnt, none, lat);
      chk("clz_abc_cnt", cnt, 20); chk("clz_abc_none", none, 0); chk("clz_abc_lat", lat, 6);
      run_op(2'b01, 64'h0000_0ABC, cnt, none, lat);
      chk("ctz_abc_cnt", cnt, 2); chk("ctz_abc_lat", lat, 1);
      run_op(2'b10, 64'hF000_0000, cnt, none, lat);
      chk("clo_f0_cnt", cnt, 4); chk("clo_f0_lat", lat, 2);
      run_op(2'b11, 64'h0000_0007, cnt, none, lat);
      chk("cto_7_cnt", cnt, 3); chk("cto_7_lat", lat, 1);
      run_op(2'b00, 64'h0, cnt, none, lat);
      chk("clz_0_cnt", cnt, 32); chk("clz_0_none", none, 1); chk("clz_0_lat", lat, 8);
      run_op(2'b11, 64'hFFFF_FFFF, cnt, none, lat);
      chk("cto_f_cnt", cnt, 32); chk("cto_f_none", none, 1); chk("cto_f_lat", lat, 8);

      // Backpressure: hold result 5 cycles with a competing operand pending
      issue(2'b00, 64'h00F0_0000);
      wait_valid(lat);
      chk("bp_lat", lat, 3);
      drv_data  = 64'h1;
      drv_op    = 2'b00;
      drv_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_valid", int'(obs_valid), 1);
         chk("bp_count", int'(obs_count), 8);
         chk("bp_none", int'(obs_none), 0);
         chk("bp_in_ready", int'(obs_in_ready), 0);
      end
      drv_ready = 1'b1;
      step();
      drv_ready = 1'b0;
      chk("bp_idle_after_drain", int'(obs_in_ready), 1);
      chk("bp_valid_after_drain", int'(obs_valid), 0);
      step();
      drv_valid = 1'b0;
      chk("bp_accepted", int'(obs_in_ready), 0);
      wait_valid(lat);
      chk("bp_new_cnt", int'(obs_count), 31);
      chk("bp_new_lat", lat, 8);
      drain();

      // Reset on the 3rd SCAN cycle of a CLZ of 0
      issue(2'b00, 64'h0);
      step();
      step();
      reset = 1'b0;
      step();
      chk("mid_rst_in_ready", int'(obs_in_ready), 1);
      chk("mid_rst_valid", int'(obs_valid), 0);
      chk("mid_rst_count", int'(obs_count), 0);
      chk("mid_rst_none", int'(obs_none), 0);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (obs_valid) seen++;
      end
      chk("mid_rst_no_result", seen, 0);

      // Random sweep over all three geometries and all four modes
      for (int s = 0; s < 3; s++) begin
         sel = s;
         w = (s == 0) ? 32 : (s == 1) ? 16 : 64;
         c = (s == 0) ? 4 : (s == 1) ? 2 : 8;
         mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
         #1;
         for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            d  = {$urandom, $urandom};
            sh = $urandom_range(w, 0);
            case ($urandom_range(3, 0))
               0: d = d >> sh;
               1: d = d << sh;
               2: d = '0;
               default: ;
            endcase
            if ($urandom_range(1, 0) == 1) d = ~d;
            d  = d & mask;
            op = 2'(n % 4);
            exp_cnt = ref_count(d, w, op);
            exp_lat = (exp_cnt == w) ? (w / c) : (exp_cnt / c + 1);
            run_op(op, d, cnt, none, lat);
            chk("rnd_cnt", cnt, exp_cnt);
            chk("rnd_none", none, (exp_cnt == w) ? 1 : 0);
            chk("rnd_lat", lat, exp_lat);
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
